fifo_ctrl: RTL and testbench

- Pointer and flag controller that sequences the dual-address synchronous register file, turning it into a circular-buffer FIFO.
- Takes push/pop requests from producer/consumer.
- Drives the register file's write enable, write address and read address.
- Reports full/empty, almost-full/almost-empty and occupancy to the surrounding design.

---
 rtl/fifo_ctrl.sv | 139 +++++++++++++
 tb/tb_fifo_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller that turns a dual-address synchronous
// register file (registered read) into a circular-buffer FIFO.
// Optional sticky overflow/underflow error flags are compiled in when the
// macro FIFO_CTRL_ERR_FLAGS_EN is defined; without it those ports and their
// logic are absent and all other behaviour is identical.
module fifo_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
);

    // Thresholds resized once so the flag compares are width-matched.
    localparam logic [ADDR_WIDTH:0] C_AF_LEVEL = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AE_LEVEL = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_ONE      = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_inc;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_inc;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  w_full_next;
    logic                  w_empty_next;

    // A request only takes effect when the FIFO can honour it; this is what
    // makes wr&rd on empty a pure write and wr&rd on full a pure read.
    assign w_push       = wr & ~r_full;
    assign w_pop        = rd & ~r_empty;
    assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    // Next-state selection for pointers, occupancy and the full/empty flags.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        w_full_next   = r_full;
        w_empty_next  = r_empty;
        case ({w_push, w_pop})
            2'b10: begin
                w_wr_ptr_next = w_wr_ptr_inc;
                w_count_next  = r_count + C_ONE;
                w_empty_next  = 1'b0;
                w_full_next   = (w_wr_ptr_inc == r_rd_ptr);
            end
            2'b01: begin
                w_rd_ptr_next = w_rd_ptr_inc;
                w_count_next  = r_count - C_ONE;
                w_full_next   = 1'b0;
                w_empty_next  = (w_rd_ptr_inc == r_wr_ptr);
            end
            2'b11: begin
                // Occupancy is unchanged, so count and flags hold.
                w_wr_ptr_next = w_wr_ptr_inc;
                w_rd_ptr_next = w_rd_ptr_inc;
            end
            default: ;
        endcase
    end

    // State register; reset discards contents by collapsing the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_full   <= w_full_next;
            r_empty  <= w_empty_next;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a new error event outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr & r_full)
                r_overflow <= 1'b1;
            else if (err_clr)
                r_overflow <= 1'b0;
            if (rd & r_empty)
                r_underflow <= 1'b1;
            else if (err_clr)
                r_underflow <= 1'b0;
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign wr_en        = w_push;
    assign w_addr       = r_wr_ptr;
    assign r_addr       = r_rd_ptr;
    assign full         = r_full;
    assign empty        = r_empty;
    assign count        = r_count;
    // Threshold flags are plain compares on the registered count.
    assign almost_full  = (r_count >= C_AF_LEVEL);
    assign almost_empty = (r_count <= C_AE_LEVEL);

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl (ADDR_WIDTH=2, AF=3, AE=1).
// A small register-file model with registered read sits beside the DUT so
// data ordering and read latency can be observed on r_data.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       wr_en;
    logic [1:0] w_addr;
    logic [1:0] r_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
    logic [7:0] r_data;
    logic [7:0] mem [0:3];

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .wr_en        (wr_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

`ifndef FIFO_CTRL_ERR_FLAGS_EN
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // Register file being sequenced: write at the edge, registered read.
    always @(posedge clk) begin
        if (wr_en)
            mem[w_addr] <= wdata;
        r_data <= mem[r_addr];
    end

    typedef struct {
        int         idx;
        logic       chk;
        logic       en;
        logic [2:0] cnt;
        logic [1:0] wa;
        logic [1:0] ra;
        logic       ovf;
        logic       udf;
        logic       dchk;
        logic [7:0] dexp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_idx  = 0;

    task automatic check(input string name, input int idx, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL cyc=%0d %s actual=%0h expected=%0h", idx, name, act, expv);
        end
    endtask

    // Monitor: every falling edge, compare the outputs against the entry
    // the stimulus queued for the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) begin
                    check("wr_en",        e.idx, int'(wr_en),        int'(e.en));
                    check("count",        e.idx, int'(count),        int'(e.cnt));
                    check("w_addr",       e.idx, int'(w_addr),       int'(e.wa));
                    check("r_addr",       e.idx, int'(r_addr),       int'(e.ra));
                    check("full",         e.idx, int'(full),         int'(e.cnt == 3'd4));
                    check("empty",        e.idx, int'(empty),        int'(e.cnt == 3'd0));
                    check("almost_full",  e.idx, int'(almost_full),  int'(e.cnt >= 3'd3));
                    check("almost_empty", e.idx, int'(almost_empty), int'(e.cnt <= 3'd1));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
                    check("overflow",     e.idx, int'(overflow),     int'(e.ovf));
                    check("underflow",    e.idx, int'(underflow),    int'(e.udf));
`endif
                    if (e.dchk)
                        check("r_data",   e.idx, int'(r_data),       int'(e.dexp));
                    $display("cyc=%0d wr=%0b rd=%0b cnt=%0d wa=%0d ra=%0d full=%0b empty=%0b af=%0b ae=%0b rdata=%02h",
                             e.idx, wr, rd, count, w_addr, r_addr, full, empty,
                             almost_full, almost_empty, r_data);
                end
            end
        end
    end

    // One cycle: drive inputs and queue what the outputs must read this cycle.
    task automatic cyc(input logic s_rst, input logic s_wr, input logic s_rd,
                       input logic [7:0] s_wd, input logic s_clr,
                       input logic chk, input logic en, input logic [2:0] cnt,
                       input logic [1:0] wa, input logic [1:0] ra,
                       input logic ovf, input logic udf,
                       input logic dchk, input logic [7:0] dexp);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = s_rst;
        wr      = s_wr;
        rd      = s_rd;
        wdata   = s_wd;
        err_clr = s_clr;
        e.idx = vec_idx; e.chk = chk; e.en = en; e.cnt = cnt; e.wa = wa; e.ra = ra;
        e.ovf = ovf; e.udf = udf; e.dchk = dchk; e.dexp = dexp;
        exp_q.push_back(e);
        vec_idx++;
    endtask

    initial begin
        //   rst wr rd wdata clr | chk en cnt wa ra ovf udf dchk dexp
        cyc(1, 0, 0, 8'h00, 0,   0, 0, 0, 0, 0, 0, 0, 0, 8'h00); // 0 reset
        cyc(0, 1, 0, 8'hA1, 0,   1, 1, 0, 0, 0, 0, 0, 0, 8'h00); // 1 reset state, push
        cyc(0, 1, 0, 8'hB2, 0,   1, 1, 1, 1, 0, 0, 0, 0, 8'h00); // 2
        cyc(0, 1, 0, 8'hC3, 0,   1, 1, 2, 2, 0, 0, 0, 0, 8'h00); // 3
        cyc(0, 1, 0, 8'hD4, 0,   1, 1, 3, 3, 0, 0, 0, 0, 8'h00); // 4 almost_full
        cyc(0, 1, 0, 8'hEE, 0,   1, 0, 4, 0, 0, 0, 0, 1, 8'hA1); // 5 full, push blocked
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 4, 0, 0, 1, 0, 0, 8'h00); // 6 overflow sticky
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 4, 0, 0, 1, 0, 0, 8'h00); // 7
        cyc(0, 0, 0, 8'h00, 1,   1, 0, 4, 0, 0, 1, 0, 0, 8'h00); // 8 clear
        cyc(0, 1, 1, 8'hEF, 0,   1, 0, 4, 0, 0, 0, 0, 1, 8'hA1); // 9 wr&rd full -> pop only
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 3, 0, 1, 1, 0, 0, 8'h00); // 10
        cyc(0, 0, 1, 8'h00, 0,   1, 0, 3, 0, 1, 1, 0, 1, 8'hB2); // 11 pop
        cyc(0, 0, 0, 8'h00, 1,   1, 0, 2, 0, 2, 1, 0, 0, 8'h00); // 12 clear
        cyc(0, 0, 1, 8'h00, 0,   1, 0, 2, 0, 2, 0, 0, 1, 8'hC3); // 13 pop
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 1, 0, 3, 0, 0, 0, 8'h00); // 14 almost_empty
        cyc(0, 0, 1, 8'h00, 0,   1, 0, 1, 0, 3, 0, 0, 1, 8'hD4); // 15 pop last
        cyc(0, 0, 1, 8'h00, 0,   1, 0, 0, 0, 0, 0, 0, 0, 8'h00); // 16 rd when empty
        cyc(0, 1, 1, 8'h11, 0,   1, 1, 0, 0, 0, 0, 1, 0, 8'h00); // 17 wr&rd empty -> write only
        cyc(0, 1, 0, 8'h22, 0,   1, 1, 1, 1, 0, 0, 1, 0, 8'h00); // 18
        cyc(0, 1, 1, 8'h33, 0,   1, 1, 2, 2, 0, 0, 1, 1, 8'h11); // 19 streaming at count 2
        cyc(0, 1, 1, 8'h44, 0,   1, 1, 2, 3, 1, 0, 1, 0, 8'h00); // 20
        cyc(0, 1, 1, 8'h55, 0,   1, 1, 2, 0, 2, 0, 1, 0, 8'h00); // 21
        cyc(0, 1, 1, 8'h66, 0,   1, 1, 2, 1, 3, 0, 1, 0, 8'h00); // 22
        cyc(0, 1, 1, 8'h77, 0,   1, 1, 2, 2, 0, 0, 1, 0, 8'h00); // 23
        cyc(0, 1, 1, 8'h88, 0,   1, 1, 2, 3, 1, 0, 1, 0, 8'h00); // 24
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 2, 0, 2, 0, 1, 0, 8'h00); // 25
        cyc(0, 0, 1, 8'h00, 1,   1, 0, 2, 0, 2, 0, 1, 1, 8'h77); // 26 pop + clear
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 1, 0, 3, 0, 0, 0, 8'h00); // 27
        cyc(0, 0, 1, 8'h00, 0,   1, 0, 1, 0, 3, 0, 0, 1, 8'h88); // 28
        cyc(0, 1, 0, 8'h01, 0,   1, 1, 0, 0, 0, 0, 0, 0, 8'h00); // 29 refill
        cyc(0, 1, 0, 8'h02, 0,   1, 1, 1, 1, 0, 0, 0, 0, 8'h00); // 30
        cyc(0, 1, 0, 8'h03, 0,   1, 1, 2, 2, 0, 0, 0, 0, 8'h00); // 31
        cyc(0, 1, 0, 8'h04, 0,   1, 1, 3, 3, 0, 0, 0, 0, 8'h00); // 32
        cyc(0, 1, 1, 8'h05, 0,   1, 0, 4, 0, 0, 0, 0, 0, 8'h00); // 33 wr&rd full
        cyc(0, 1, 0, 8'h06, 0,   1, 1, 3, 0, 1, 1, 0, 0, 8'h00); // 34
        cyc(0, 0, 1, 8'h00, 0,   1, 0, 4, 1, 1, 1, 0, 0, 8'h00); // 35
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 3, 1, 2, 1, 0, 0, 8'h00); // 36 count 3
        cyc(1, 0, 0, 8'h00, 0,   1, 0, 3, 1, 2, 1, 0, 0, 8'h00); // 37 reset mid-run
        cyc(0, 0, 1, 8'h00, 0,   1, 0, 0, 0, 0, 0, 0, 0, 8'h00); // 38 rd after reset ignored
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 0, 0, 0, 0, 1, 0, 8'h00); // 39
        cyc(0, 0, 1, 8'h00, 1,   1, 0, 0, 0, 0, 0, 1, 0, 8'h00); // 40 clear vs event
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 0, 0, 0, 0, 1, 0, 8'h00); // 41 set won
        cyc(0, 0, 0, 8'h00, 1,   1, 0, 0, 0, 0, 0, 1, 0, 8'h00); // 42 clear
        cyc(0, 0, 0, 8'h00, 0,   1, 0, 0, 0, 0, 0, 0, 0, 8'h00); // 43
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
